hazard_detection_unit: RTL

Pipeline stall, flush and halt controller for the five-stage MIPS pipeline; it sits beside the ID stage, complementary to the MEM/WB forwarding unit. Some dependences cannot be covered by forwarding: load-use, and branches resolved in ID that depend on EX results. For these it freezes PC and IF/ID and injects bubbles into ID/EX. It also flushes IF/ID on taken branches and jumps. On a halt it drains the pipeline and reports `halted` plus a saturating stall-cycle count to the debug unit.

---
 rtl/hazard_detection_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//
// Stall, flush and halt controller for the five-stage MIPS pipeline. It sits beside
// the ID stage and covers the dependences that forwarding cannot:
//   - load-use: one stall cycle;
//   - ALU->branch resolved in ID: one stall cycle;
//   - load->branch: two stall cycles (RUN stall followed by HOLD).
// It flushes IF/ID on taken branches and jumps. On HALT it drains the pipeline for
// DRAIN_CYCLES enabled cycles and then reports `halted` until reset.
//
// Ports:
//   clk, reset             clock (rising edge), synchronous active-high reset
//   enable                 debug step/run enable; low freezes state and zeroes controls
//   reg_write_from_ex      EX instruction writes a register
//   mem_read_from_ex       EX instruction is a load
//   reg_dst_add_from_ex    EX destination register
//   reg_rs_add_from_dec    ID rs
//   reg_rt_add_from_dec    ID rt
//   uses_rt_from_dec       ID instruction reads rt
//   branch_from_dec        ID instruction is a conditional branch
//   branch_taken_from_dec  branch resolved taken in ID
//   jump_from_dec          ID instruction is a jump
//   halt_from_dec          ID instruction is HALT
//   pc_write               PC update enable
//   if_id_write            IF/ID write enable
//   id_ex_bubble           zero the ID/EX control fields
//   if_id_flush            clear IF/ID to a NOP
//   halted                 pipeline drained after HALT (registered)
//   stall_count            saturating count of stall cycles since reset (registered)

module hazard_detection_unit #(
  parameter int unsigned ADDR_BITS     = 32,
  parameter int unsigned REG_ADD_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned DRAIN_CYCLES  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 reg_write_from_ex,
  input  logic                 mem_read_from_ex,
  input  logic [ADDR_BITS-1:0] reg_dst_add_from_ex,
  input  logic [ADDR_BITS-1:0] reg_rs_add_from_dec,
  input  logic [ADDR_BITS-1:0] reg_rt_add_from_dec,
  input  logic                 uses_rt_from_dec,
  input  logic                 branch_from_dec,
  input  logic                 branch_taken_from_dec,
  input  logic                 jump_from_dec,
  input  logic                 halt_from_dec,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {StRun, StHold, StDrain, StHalted} state_e;

  state_e                state_q;
  logic [DrainW-1:0]     drain_q;
  logic                  halted_q;
  logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

  // Address comparison on the low register-index bits only; r0 never matches.
  logic [REG_ADD_WIDTH-1:0] dst, rs, rt;
  logic                     rs_eq, rt_eq;
  logic                     m_rs, m_rt, lu, br, brl, haz;
  logic                     stall;

  assign dst = reg_dst_add_from_ex[REG_ADD_WIDTH-1:0];
  assign rs  = reg_rs_add_from_dec[REG_ADD_WIDTH-1:0];
  assign rt  = reg_rt_add_from_dec[REG_ADD_WIDTH-1:0];

  assign rs_eq = (|dst) && (rs == dst);
  assign rt_eq = (|dst) && (rt == dst);

  assign m_rs = rs_eq;
  assign m_rt = uses_rt_from_dec && rt_eq;
  assign lu   = mem_read_from_ex && (m_rs || m_rt);
  // Branches compare both operands, so rt counts regardless of uses_rt.
  assign br   = branch_from_dec && reg_write_from_ex && (rs_eq || rt_eq);
  assign brl  = br && mem_read_from_ex;
  assign haz  = lu || br;

  if (ADDR_BITS > REG_ADD_WIDTH) begin : g_unused_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{reg_dst_add_from_ex[ADDR_BITS-1:REG_ADD_WIDTH],
                              reg_rs_add_from_dec[ADDR_BITS-1:REG_ADD_WIDTH],
                              reg_rt_add_from_dec[ADDR_BITS-1:REG_ADD_WIDTH]};
  end

  // Control outputs are combinational from state and inputs.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stall        = 1'b0;
    if (enable) begin
      unique case (state_q)
        StRun: begin
          if (haz) begin
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
          end else if (halt_from_dec) begin
            // HALT proceeds into EX while the front end freezes.
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = jump_from_dec || (branch_from_dec && branch_taken_from_dec);
          end
        end
        StHold: begin
          id_ex_bubble = 1'b1;
          stall        = 1'b1;
        end
        StDrain, StHalted: begin
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      drain_q       <= DrainInit;
      halted_q      <= 1'b0;
      stall_count_q <= '0;
    end else if (enable) begin
      stall_count_q <= stall_count_d;
      unique case (state_q)
        StRun: begin
          if (haz) begin
            if (brl) state_q <= StHold;
          end else if (halt_from_dec) begin
            state_q <= StDrain;
            drain_q <= DrainInit;
          end
        end
        StHold: state_q <= StRun;
        StDrain: begin
          if (drain_q == DrainW'(1)) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        StHalted: ;
        default: state_q <= StRun;
      endcase
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_count_q;

endmodule
